fp_unpack_ff: RTL and testbench

FP_UNPACK_FF -- requirements
Module: fp_unpack_ff

---
 rtl/fp_unpack_ff.sv | 157 +++++++++++++++
 tb/tb_fp_unpack_ff.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_unpack_ff.sv
// -----------------------------------------------------------------------------
// fp_unpack_ff
//   Unpacks IEEE 754 single-precision words into multiplier-operand form
//   (sign, effective biased exponent, 24-bit mantissa with explicit hidden bit,
//   class flags) and queues the decoded result in a small FIFO with
//   valid/ready handshakes on both sides. Decode is combinational ahead of the
//   buffer write, so an accepted word is visible on the outputs one edge later.
//
// Parameters
//   FLUSH_DENORM : 1 = subnormals become signed zero (flags zero+denorm)
//                  0 = subnormals pass with hidden bit 0 and exponent 1
//   DEPTH        : buffer entries, power of two, >= 2
//
// Ports
//   clk        in   clock, all state changes on rising edge
//   clr_b      in   asynchronous active-low reset
//   in_valid   in   in_word is valid this cycle
//   in_ready   out  buffer has room (derived from registered count only)
//   in_word    in   {S[31], E[30:23], F[22:0]}
//   out_valid  out  head entry present on out_*
//   out_ready  in   consumer takes head entry this cycle
//   out_S      out  sign
//   out_E      out  biased exponent (effective value)
//   out_M      out  mantissa, hidden bit at [23]
//   out_flags  out  {nan, inf, denorm, zero}
// -----------------------------------------------------------------------------
module fp_unpack_ff #(
  parameter bit FLUSH_DENORM = 1'b1,
  parameter int DEPTH        = 2
) (
  input  logic        clk,
  input  logic        clr_b,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_S,
  output logic [7:0]  out_E,
  output logic [23:0] out_M,
  output logic [3:0]  out_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 1 + 8 + 24 + 4;  // {S, E, M, flags}

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // ---------------------------------------------------------------------------
  logic          in_s;
  logic [7:0]    in_e;
  logic [22:0]   in_f;
  logic [7:0]    dec_e;
  logic [23:0]   dec_m;
  logic [3:0]    dec_flags;
  logic [EW-1:0] dec_entry;

  assign in_s = in_word[31];
  assign in_e = in_word[30:23];
  assign in_f = in_word[22:0];

  always_comb begin
    dec_e     = in_e;
    dec_m     = {1'b1, in_f};
    dec_flags = 4'b0000;
    if (in_e == 8'hFF) begin
      // Infinity keeps the hidden bit so the operand reads as 1.0 x 2^128;
      // NaN payload is passed through untouched.
      dec_m     = {1'b1, in_f};
      dec_flags = (in_f == 23'd0) ? 4'b0100 : 4'b1000;
    end else if (in_e == 8'h00) begin
      if (in_f == 23'd0) begin
        dec_m     = 24'd0;
        dec_flags = 4'b0001;
      end else if (FLUSH_DENORM) begin
        dec_m     = 24'd0;
        dec_flags = 4'b0011;
      end else begin
        // Subnormals share the scale of E=1, just without the hidden bit.
        dec_e     = 8'd1;
        dec_m     = {1'b0, in_f};
        dec_flags = 4'b0010;
      end
    end
  end

  assign dec_entry = {in_s, dec_e, dec_m, dec_flags};

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;

  // in_ready looks only at the registered count, so a full buffer does not
  // accept a word in the same cycle it is being popped.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) begin
      wr_d = wr_q + AW'(1);
    end
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge clr_b) begin
    if (!clr_b) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage; cleared on reset so the outputs read zero while clr_b=0.
  // ---------------------------------------------------------------------------
  logic [EW-1:0] entry_q [DEPTH];
  logic [EW-1:0] head;

  always_ff @(posedge clk or negedge clr_b) begin
    if (!clr_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else if (push) begin
      entry_q[wr_q] <= dec_entry;
    end
  end

  assign head      = entry_q[rd_q];
  assign out_S     = head[36];
  assign out_E     = head[35:28];
  assign out_M     = head[27:4];
  assign out_flags = head[3:0];

endmodule

// File: tb/tb_fp_unpack_ff.sv
// -----------------------------------------------------------------------------
// tb_fp_unpack_ff
//   Drives two instances (flush and pass-through subnormals, DEPTH=2) from the
//   same stimulus. A queue-based model of the buffer plus a rule-based decode
//   function predicts every output each cycle; directed literal checks pin the
//   model on the documented cases, then a randomized phase exercises the rest.
// -----------------------------------------------------------------------------
module tb_fp_unpack_ff;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        clr_b;
  logic        in_valid;
  logic [31:0] in_word;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_S_a;
  logic [7:0]  out_E_a;
  logic [23:0] out_M_a;
  logic [3:0]  out_flags_a;

  logic        in_ready_b, out_valid_b, out_S_b;
  logic [7:0]  out_E_b;
  logic [23:0] out_M_b;
  logic [3:0]  out_flags_b;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [31:0] mq[$];

  always #5 clk = ~clk;

  fp_unpack_ff #(.FLUSH_DENORM(1'b1), .DEPTH(DEPTH)) dut_a (
    .clk(clk), .clr_b(clr_b), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_word(in_word), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_S(out_S_a), .out_E(out_E_a), .out_M(out_M_a), .out_flags(out_flags_a)
  );

  fp_unpack_ff #(.FLUSH_DENORM(1'b0), .DEPTH(DEPTH)) dut_b (
    .clk(clk), .clr_b(clr_b), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_word(in_word), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_S(out_S_b), .out_E(out_E_b), .out_M(out_M_b), .out_flags(out_flags_b)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Rule-based decode: value class first, then the fields each class defines.
  function automatic logic [36:0] ref_dec(input logic [31:0] w, input bit flush);
    logic       s;
    int         e;
    int         f;
    logic [7:0] re;
    int         rm;
    logic [3:0] fl;
    s = w[31];
    e = int'(w[30:23]);
    f = int'(w[22:0]);
    if (e == 255 && f == 0) begin
      re = 8'd255; rm = 32'h800000; fl = 4'b0100;
    end else if (e == 255) begin
      re = 8'd255; rm = 32'h800000 + f; fl = 4'b1000;
    end else if (e == 0 && f == 0) begin
      re = 8'd0; rm = 0; fl = 4'b0001;
    end else if (e == 0 && flush) begin
      re = 8'd0; rm = 0; fl = 4'b0011;
    end else if (e == 0) begin
      re = 8'd1; rm = f; fl = 4'b0010;
    end else begin
      re = 8'(e); rm = 32'h800000 + f; fl = 4'b0000;
    end
    return {s, re, rm[23:0], fl};
  endfunction

  // Model: buffer contents as a queue of raw words.
  always @(negedge clr_b) mq.delete();

  always @(posedge clk) begin
    if (clr_b) begin
      bit do_pop;
      bit do_push;
      do_pop  = (mq.size() != 0) && out_ready;
      do_push = in_valid && (mq.size() < DEPTH);
      if (do_pop) begin
        $display("xfer out word=%08h t=%0t", mq[0], $time);
        void'(mq.pop_front());
      end
      if (do_push) begin
        $display("xfer in  word=%08h t=%0t", in_word, $time);
        mq.push_back(in_word);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (!clr_b) begin
        chk("rst_in_ready", {in_ready_a, in_ready_b}, 2'b11);
        chk("rst_out_valid", {out_valid_a, out_valid_b}, 2'b00);
        chk("rst_out_a", {out_S_a, out_E_a, out_M_a, out_flags_a}, 37'd0);
        chk("rst_out_b", {out_S_b, out_E_b, out_M_b, out_flags_b}, 37'd0);
      end else begin
        chk("in_ready_a", in_ready_a, mq.size() < DEPTH);
        chk("in_ready_b", in_ready_b, mq.size() < DEPTH);
        chk("out_valid_a", out_valid_a, mq.size() != 0);
        chk("out_valid_b", out_valid_b, mq.size() != 0);
        if (mq.size() != 0) begin
          chk("head_a", {out_S_a, out_E_a, out_M_a, out_flags_a}, ref_dec(mq[0], 1'b1));
          chk("head_b", {out_S_b, out_E_b, out_M_b, out_flags_b}, ref_dec(mq[0], 1'b0));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: w[30:0] = 31'd0;
      1: begin w[30:23] = 8'h00; if (w[22:0] == 23'd0) w[0] = 1'b1; end
      2: begin w[30:23] = 8'hFF; w[22:0] = 23'd0; end
      3: begin w[30:23] = 8'hFF; if (w[22:0] == 23'd0) w[5] = 1'b1; end
      default: if (w[30:23] == 8'h00 || w[30:23] == 8'hFF) w[30:23] = 8'h80;
    endcase
    return w;
  endfunction

  initial begin
    clr_b     = 1'b0;
    in_valid  = 1'b1;            // must be ignored during reset
    in_word   = 32'h3F800000;
    out_ready = 1'b0;
    chk_en    = 1'b1;
    step();
    step();
    chk("reset_in_ready", in_ready_a, 1'b1);
    chk("reset_out_valid", out_valid_a, 1'b0);
    chk("reset_out", {out_S_a, out_E_a, out_M_a, out_flags_a}, 37'd0);
    in_valid = 1'b0;
    clr_b    = 1'b1;
    step();
    chk("no_push_from_reset", out_valid_a, 1'b0);

    // Normal number, one-cycle latency.
    in_valid = 1'b1; in_word = 32'h3FC00000; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("norm_valid", out_valid_a, 1'b1);
    chk("norm_fields", {out_S_a, out_E_a, out_M_a, out_flags_a},
        {1'b0, 8'h7F, 24'hC00000, 4'b0000});
    step();
    chk("norm_drained", out_valid_a, 1'b0);

    // Zero, infinity, NaN back-to-back.
    in_valid = 1'b1; in_word = 32'h80000000;
    step();
    chk("neg_zero", {out_S_a, out_E_a, out_M_a, out_flags_a}, {1'b1, 8'h00, 24'h000000, 4'b0001});
    in_word = 32'h7F800000;
    step();
    chk("inf", {out_S_a, out_E_a, out_M_a, out_flags_a}, {1'b0, 8'hFF, 24'h800000, 4'b0100});
    in_word = 32'h7FC00001;
    step();
    chk("nan", {out_S_a, out_E_a, out_M_a, out_flags_a}, {1'b0, 8'hFF, 24'hC00001, 4'b1000});
    in_valid = 1'b0;
    step();

    // Smallest subnormal, flushed and passed.
    in_valid = 1'b1; in_word = 32'h00000001;
    step();
    in_valid = 1'b0;
    chk("denorm_flush", {out_S_a, out_E_a, out_M_a, out_flags_a}, {1'b0, 8'h00, 24'h000000, 4'b0011});
    chk("denorm_pass", {out_S_b, out_E_b, out_M_b, out_flags_b}, {1'b0, 8'h01, 24'h000001, 4'b0010});
    step();

    // Backpressure: three words offered into a DEPTH=2 buffer.
    out_ready = 1'b0; in_valid = 1'b1; in_word = 32'h40000000;
    step();
    chk("bp_ready_after1", in_ready_a, 1'b1);
    in_word = 32'h40400000;
    step();
    chk("bp_full_ready", in_ready_a, 1'b0);
    chk("bp_head_w1", {out_E_a, out_M_a}, {8'h80, 24'h800000});
    in_word = 32'h40800000;
    step();
    chk("bp_hold_ready", in_ready_a, 1'b0);
    chk("bp_hold_head", {out_E_a, out_M_a}, {8'h80, 24'h800000});
    out_ready = 1'b1;
    step();
    chk("bp_pop1_head", {out_E_a, out_M_a}, {8'h80, 24'hC00000});
    chk("bp_pop1_ready", in_ready_a, 1'b1);
    step();
    chk("bp_w3_head", {out_E_a, out_M_a}, {8'h81, 24'h800000});
    in_valid = 1'b0;
    step();
    chk("bp_empty", out_valid_a, 1'b0);

    // Fill, then stream with both sides active across pointer wrap.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_word = rand_word();
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_word = rand_word();
      step();
    end
    in_valid = 1'b0;
    step(); step(); step();
    chk("stream_drained", out_valid_a, 1'b0);

    // Asynchronous reset between edges with two entries held.
    out_ready = 1'b0; in_valid = 1'b1; in_word = 32'h3F800000;
    step();
    in_word = 32'hBF800000;
    step();
    in_valid = 1'b0;
    chk("pre_rst_full", in_ready_a, 1'b0);
    #2 clr_b = 1'b0;
    #1;
    chk("async_rst_valid", out_valid_a, 1'b0);
    chk("async_rst_ready", in_ready_a, 1'b1);
    chk("async_rst_out", {out_S_a, out_E_a, out_M_a, out_flags_a}, 37'd0);
    step();
    #2 clr_b = 1'b1;
    out_ready = 1'b1;
    step();
    chk("no_stale_after_rst", out_valid_a, 1'b0);
    step();
    chk("no_stale_after_rst2", out_valid_b, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_word   = rand_word();
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step(); step(); step();
    chk("final_empty", out_valid_a, 1'b0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
